// File: rtl/encoder_32_scan.sv
// Multi-hot 32-bit vector to serial stream of set-bit indices, lowest first, valid/ready on both sides.
// Define ENC_ZERO_FLAG_EN to emit a single flagged beat (out_zero) for an all-zero vector instead of dropping it.
module encoder_32_scan (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_vec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic        busy
`ifdef ENC_ZERO_FLAG_EN
    ,
    output logic        out_zero
`endif
);

`ifdef ENC_ZERO_FLAG_EN
    localparam bit ZeroEn = 1'b1;
`else
    localparam bit ZeroEn = 1'b0;
`endif

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state, state_next;
    logic [31:0] pend, pend_next;
    logic        zero_beat, zero_next;
    logic [4:0]  low_idx;
    logic        pend_onehot;
    logic        accept, advance;

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state     <= IDLE;
            pend      <= '0;
            zero_beat <= 1'b0;
        end else begin
            state     <= state_next;
            pend      <= pend_next;
            zero_beat <= zero_next;
        end
    end

    // Scan high-to-low so the last hit written is the lowest set bit.
    always_comb begin
        low_idx = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (pend[31 - i]) low_idx = 5'(31 - i);
        end
    end

    assign pend_onehot = (pend != '0) && ((pend & (pend - 32'd1)) == '0);

    always_comb begin
        busy      = (state == EMIT);
        out_valid = busy;
        out_index = busy ? low_idx : '0;
        out_last  = busy && (zero_beat || pend_onehot);
        in_ready  = !busy || (out_last && out_ready);
        accept    = in_valid && in_ready;
        advance   = out_valid && out_ready;
    end

    always_comb begin
        state_next = state;
        pend_next  = pend;
        zero_next  = zero_beat;
        if (advance) begin
            pend_next = pend & (pend - 32'd1);
            if (out_last) begin
                state_next = IDLE;
                pend_next  = '0;
                zero_next  = 1'b0;
            end
        end
        // A load during the final beat overrides the return to IDLE (zero-bubble reload).
        if (accept) begin
            pend_next  = in_vec;
            zero_next  = ZeroEn && (in_vec == '0);
            state_next = ((in_vec != '0) || ZeroEn) ? EMIT : IDLE;
        end
    end

`ifdef ENC_ZERO_FLAG_EN
    assign out_zero = busy && zero_beat;
`endif

endmodule

// File: tb/tb_encoder_32_scan.sv
// Directed self-checking bench for encoder_32_scan; each task drives one scenario and checks inline.
module tb_encoder_32_scan;

    logic        clock;
    logic        ctrl_reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
`ifdef ENC_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int vectors;
    int miscompares;

    encoder_32_scan dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy)
`ifdef ENC_ZERO_FLAG_EN
        ,
        .out_zero   (out_zero)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Outputs are observed 2 time units after the active edge.
    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    // Present vec for one edge, then scramble in_vec to show later changes are ignored.
    task automatic load(input logic [31:0] vec);
        in_valid = 1'b1;
        in_vec   = vec;
        tick();
        in_valid = 1'b0;
        in_vec   = 32'hA5A5_5A5A;
    endtask

    task automatic test_reset;
        logic [8:0] got;
        ctrl_reset = 1'b1;
        in_valid   = 1'b0;
        in_vec     = '0;
        out_ready  = 1'b0;
        #3;
        got = {in_ready, out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== 9'b1_0_00000_0_0) begin
            miscompares++;
            $display("FAIL reset_during: got %b want %b", got, 9'b1_0_00000_0_0);
        end
        tick();
        tick();
        @(negedge clock);
        ctrl_reset = 1'b0;
        tick();
        got = {in_ready, out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== 9'b1_0_00000_0_0) begin
            miscompares++;
            $display("FAIL reset_after: got %b want %b", got, 9'b1_0_00000_0_0);
        end
    endtask

    task automatic test_two_bits;
        logic [7:0] got;
        logic [7:0] exp [3];
        // {out_valid, out_index, out_last, busy}
        exp[0] = {1'b1, 5'd0,  1'b0, 1'b1};
        exp[1] = {1'b1, 5'd31, 1'b1, 1'b1};
        exp[2] = {1'b0, 5'd0,  1'b0, 1'b0};
        out_ready = 1'b1;
        load(32'h8000_0001);
        for (int i = 0; i < 3; i++) begin
            got = {out_valid, out_index, out_last, busy};
            vectors++;
            if (got !== exp[i]) begin
                miscompares++;
                $display("FAIL two_bits beat%0d: got %b want %b", i, got, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_all_ones;
        logic [7:0] got;
        logic [7:0] exp;
        out_ready = 1'b1;
        load(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            got = {out_valid, out_index, out_last, busy};
            exp = {1'b1, 5'(i), (i == 31), 1'b1};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL all_ones beat%0d: got %b want %b", i, got, exp);
            end
            tick();
        end
        got = {out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== 8'b0_00000_0_0) begin
            miscompares++;
            $display("FAIL all_ones idle: got %b want %b", got, 8'b0_00000_0_0);
        end
    endtask

    task automatic test_stall;
        logic [8:0] got;
        logic [8:0] exp;
        out_ready = 1'b0;
        load(32'h0000_0110);
        // {in_ready, out_valid, out_index, out_last, busy}
        exp = {1'b0, 1'b1, 5'd4, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            got = {in_ready, out_valid, out_index, out_last, busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL stall cycle%0d: got %b want %b", i, got, exp);
            end
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        #1;
        got = {in_ready, out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL stall release: got %b want %b", got, exp);
        end
        tick();
        exp = {1'b1, 1'b1, 5'd8, 1'b1, 1'b1};
        got = {in_ready, out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL stall beat8: got %b want %b", got, exp);
        end
        tick();
        got = {in_ready, out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== 9'b1_0_00000_0_0) begin
            miscompares++;
            $display("FAIL stall idle: got %b want %b", got, 9'b1_0_00000_0_0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] got;
        out_ready = 1'b1;
        load(32'h0000_0008);
        got = {out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== {1'b1, 5'd3, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b first: got %b want %b", got, {1'b1, 5'd3, 1'b1, 1'b1});
        end
        in_valid = 1'b1;
        in_vec   = 32'h0000_0003;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b in_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_vec   = 32'hFFFF_0000;
        got = {out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== {1'b1, 5'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b beat0: got %b want %b", got, {1'b1, 5'd0, 1'b0, 1'b1});
        end
        tick();
        got = {out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== {1'b1, 5'd1, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b beat1: got %b want %b", got, {1'b1, 5'd1, 1'b1, 1'b1});
        end
        tick();
        got = {out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== 8'b0_00000_0_0) begin
            miscompares++;
            $display("FAIL b2b idle: got %b want %b", got, 8'b0_00000_0_0);
        end
    endtask

    task automatic test_reset_mid;
        logic [8:0] got;
        out_ready = 1'b1;
        load(32'h0000_F000);
        got = {in_ready, out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== {1'b0, 1'b1, 5'd12, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rstmid beat12: got %b want %b", got, {1'b0, 1'b1, 5'd12, 1'b0, 1'b1});
        end
        tick();
        #1;
        ctrl_reset = 1'b1;
        #1;
        got = {in_ready, out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== 9'b1_0_00000_0_0) begin
            miscompares++;
            $display("FAIL rstmid async: got %b want %b", got, 9'b1_0_00000_0_0);
        end
        @(negedge clock);
        ctrl_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            got = {in_ready, out_valid, out_index, out_last, busy};
            vectors++;
            if (got !== 9'b1_0_00000_0_0) begin
                miscompares++;
                $display("FAIL rstmid after%0d: got %b want %b", i, got, 9'b1_0_00000_0_0);
            end
        end
    endtask

    task automatic test_zero;
        logic [8:0] got;
        out_ready = 1'b1;
        load(32'h0000_0000);
`ifdef ENC_ZERO_FLAG_EN
        got = {out_zero, out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== {1'b1, 1'b1, 5'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL zero beat: got %b want %b", got, {1'b1, 1'b1, 5'd0, 1'b1, 1'b1});
        end
        tick();
        got = {out_zero, out_valid, out_index, out_last, busy};
        vectors++;
        if (got !== 9'b0_0_00000_0_0) begin
            miscompares++;
            $display("FAIL zero idle: got %b want %b", got, 9'b0_0_00000_0_0);
        end
`else
        for (int i = 0; i < 2; i++) begin
            got = {in_ready, out_valid, out_index, out_last, busy};
            vectors++;
            if (got !== 9'b1_0_00000_0_0) begin
                miscompares++;
                $display("FAIL zero drop%0d: got %b want %b", i, got, 9'b1_0_00000_0_0);
            end
            tick();
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_two_bits();
        test_all_ones();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
